// File: rtl/u_rdiv8.sv
// 8-bit unsigned restoring divider: one quotient bit per cycle, valid/ready on both sides.
// Optional macro U_RDIV8_DIVZERO_EN adds the u_rdiv8_dz port and a one-cycle divide-by-zero path.
module u_rdiv8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] u_rdiv8_q,
    output logic [7:0] u_rdiv8_r
`ifdef U_RDIV8_DIVZERO_EN
    ,
    output logic       u_rdiv8_dz
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  q_q, q_d;
    logic [7:0]  r_q, r_d;
    logic [7:0]  b_q, b_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [8:0]  t_s;
    logic [8:0]  sub_s;
    logic        borrow_s;
`ifdef U_RDIV8_DIVZERO_EN
    logic        dz_q, dz_d;
`endif

    // 9-bit generate/propagate adder; returns {carry_out, sum[7:0]}.
    function automatic logic [8:0] cla9(input logic [8:0] x, input logic [8:0] y, input logic cin);
        logic [8:0] g;
        logic [8:0] p;
        logic [9:0] c;
        logic [8:0] s;
        g    = x & y;
        p    = x ^ y;
        c[0] = cin;
        for (int i = 0; i < 9; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        s = p ^ c[8:0];
        return {c[9], s[7:0]};
    endfunction

    // T - B as T + ~B + 1; the carry out is the inverse of the borrow.
    assign t_s      = {r_q, q_q[7]};
    assign sub_s    = cla9(t_s, ~{1'b0, b_q}, 1'b1);
    assign borrow_s = ~sub_s[8];

    // Next-state logic for the FSM and datapath registers.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
`ifdef U_RDIV8_DIVZERO_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    q_d     = a;
                    r_d     = 8'd0;
                    b_d     = b;
                    cnt_d   = 4'd0;
                    state_d = CALC;
`ifdef U_RDIV8_DIVZERO_EN
                    dz_d    = (b == 8'd0);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
`ifdef U_RDIV8_DIVZERO_EN
                if (dz_q) begin
                    q_d     = 8'hFF;
                    r_d     = q_q;
                    state_d = DONE;
                end else
`endif
                // Eight steps on counts 0..7; count 8 spends one cycle entering DONE.
                if (cnt_q == 4'd8) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (borrow_s) begin
                        r_d = t_s[7:0];
                        q_d = {q_q[6:0], 1'b0};
                    end else begin
                        r_d = sub_s[7:0];
                        q_d = {q_q[6:0], 1'b1};
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            q_q         <= 8'd0;
            r_q         <= 8'd0;
            b_q         <= 8'd0;
            cnt_q       <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef U_RDIV8_DIVZERO_EN
            dz_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            r_q         <= r_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef U_RDIV8_DIVZERO_EN
            dz_q        <= dz_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign u_rdiv8_q  = q_q;
    assign u_rdiv8_r  = r_q;
`ifdef U_RDIV8_DIVZERO_EN
    assign u_rdiv8_dz = dz_q;
`endif

endmodule

// File: tb/tb_u_rdiv8.sv
// Directed self-checking bench for u_rdiv8 (latency, results, back-pressure, reset abort).
module tb_u_rdiv8;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] res_q;
    logic [7:0] res_r;
`ifdef U_RDIV8_DIVZERO_EN
    logic       dz;
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = 9;
`endif

    int checks   = 0;
    int failures = 0;

    u_rdiv8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .u_rdiv8_q (res_q),
        .u_rdiv8_r (res_r)
`ifdef U_RDIV8_DIVZERO_EN
        ,
        .u_rdiv8_dz(dz)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one division; returns cycles from acceptance to out_valid (-1 on timeout).
    task automatic do_div(input logic [7:0] da, input logic [7:0] db, input int hold,
                          input bit consume, output int lat,
                          output logic [7:0] rq, output logic [7:0] rr);
        int guard;
        lat   = -1;
        rq    = 8'd0;
        rr    = 8'd0;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 30) begin
            @(posedge clk); #1;
            guard++;
        end
        a        = da;
        b        = db;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (lat > 0) begin
            rq = res_q;
            rr = res_r;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
            end
            if (consume) begin
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'd0;
        b         = 8'd0;
        #3;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (res_q !== 8'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", res_q); end
        checks++; if (res_r !== 8'd0) begin failures++; $display("FAIL reset_r got=%0d exp=0", res_r); end
`ifdef U_RDIV8_DIVZERO_EN
        checks++; if (dz !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", dz); end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid2 got=%b exp=0", out_valid); end
    endtask

    task automatic test_basic;
        logic [7:0] va [3] = '{8'd200, 8'd255, 8'd5};
        logic [7:0] vb [3] = '{8'd7,   8'd1,   8'd9};
        logic [7:0] vq [3] = '{8'd28,  8'd255, 8'd0};
        logic [7:0] vr [3] = '{8'd4,   8'd0,   8'd5};
        int lat;
        logic [7:0] rq, rr;
        for (int i = 0; i < 3; i++) begin
            do_div(va[i], vb[i], 0, 1'b1, lat, rq, rr);
            checks++; if (lat != 9) begin failures++; $display("FAIL basic_lat[%0d] got=%0d exp=9", i, lat); end
            checks++; if (rq !== vq[i]) begin failures++; $display("FAIL basic_q[%0d] got=%0d exp=%0d", i, rq, vq[i]); end
            checks++; if (rr !== vr[i]) begin failures++; $display("FAIL basic_r[%0d] got=%0d exp=%0d", i, rr, vr[i]); end
        end
    endtask

    task automatic test_divzero;
        int lat;
        logic [7:0] rq, rr;
        do_div(8'h3C, 8'h00, 0, 1'b0, lat, rq, rr);
        checks++; if (lat != DZ_LAT) begin failures++; $display("FAIL dz_lat got=%0d exp=%0d", lat, DZ_LAT); end
        checks++; if (rq !== 8'hFF) begin failures++; $display("FAIL dz_q got=%h exp=ff", rq); end
        checks++; if (rr !== 8'h3C) begin failures++; $display("FAIL dz_r got=%h exp=3c", rr); end
`ifdef U_RDIV8_DIVZERO_EN
        checks++; if (dz !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", dz); end
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
`ifdef U_RDIV8_DIVZERO_EN
        do_div(8'd9, 8'd2, 0, 1'b0, lat, rq, rr);
        checks++; if (dz !== 1'b0) begin failures++; $display("FAIL dz_cleared got=%b exp=0", dz); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
`endif
    endtask

    task automatic test_backpressure;
        int lat;
        logic [7:0] rq, rr;
        do_div(8'd100, 8'd10, 0, 1'b0, lat, rq, rr);
        checks++; if (lat != 9) begin failures++; $display("FAIL bp_lat got=%0d exp=9", lat); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, out_valid); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
            checks++; if (res_q !== 8'd10) begin failures++; $display("FAIL bp_q[%0d] got=%0d exp=10", i, res_q); end
            checks++; if (res_r !== 8'd0) begin failures++; $display("FAIL bp_r[%0d] got=%0d exp=0", i, res_r); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_abort;
        int lat;
        int seen;
        logic [7:0] rq, rr;
        a        = 8'd77;
        b        = 8'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", out_valid); end
        checks++; if (res_q !== 8'd0) begin failures++; $display("FAIL abort_q got=%0d exp=0", res_q); end
        checks++; if (res_r !== 8'd0) begin failures++; $display("FAIL abort_r got=%0d exp=0", res_r); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL abort_no_result got=%0d exp=0", seen); end
        do_div(8'd77, 8'd3, 0, 1'b1, lat, rq, rr);
        checks++; if (rq !== 8'd25) begin failures++; $display("FAIL abort_redo_q got=%0d exp=25", rq); end
        checks++; if (rr !== 8'd2) begin failures++; $display("FAIL abort_redo_r got=%0d exp=2", rr); end
    endtask

    task automatic test_back_to_back;
        int acc_gap;
        int guard;
        a        = 8'd50;
        b        = 8'd6;
        in_valid = 1'b1;
        @(posedge clk); #1;
        guard = 0;
        while (out_valid !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_gap  = (in_ready === 1'b0) ? 1 : 0;
        checks++; if (acc_gap != 1) begin failures++; $display("FAIL b2b_accept got=%0d exp=1", acc_gap); end
        guard = 0;
        while (out_valid !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++; if (res_q !== 8'd8 || res_r !== 8'd2) begin failures++; $display("FAIL b2b_result got=%0d/%0d exp=8/2", res_q, res_r); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_sweep;
        int lat;
        int exp_lat;
        logic [7:0] rq, rr, da, db, eq, er;
        logic [15:0] recon;
        for (int i = 0; i < 200; i++) begin
            if (i < 4) begin
                da = (i[0]) ? 8'hFF : 8'h00;
                db = (i[1]) ? 8'hFF : 8'h01;
            end else begin
                da = 8'($urandom);
                db = (i % 16 == 0) ? 8'd0 : 8'($urandom);
            end
            if (db == 8'd0) begin
                eq = 8'hFF; er = da; exp_lat = DZ_LAT;
            end else begin
                eq = da / db; er = da % db; exp_lat = 9;
            end
            do_div(da, db, $urandom_range(0, 3), 1'b1, lat, rq, rr);
            checks++;
            if (lat != exp_lat || rq !== eq || rr !== er) begin
                failures++;
                $display("FAIL sweep a=%0d b=%0d got q=%0d r=%0d lat=%0d exp q=%0d r=%0d lat=%0d",
                         da, db, rq, rr, lat, eq, er, exp_lat);
            end
            if (db != 8'd0) begin
                recon = 16'(rq) * 16'(db) + 16'(rr);
                checks++;
                if (recon != 16'(da) || rr >= db) begin
                    failures++;
                    $display("FAIL sweep_identity a=%0d b=%0d got q*b+r=%0d r=%0d", da, db, recon, rr);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_divzero;
        test_backpressure;
        test_abort;
        test_back_to_back;
        test_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/u_rdiv8.md
U_RDIV8 -- requirements
Module: u_rdiv8

Interface
REQ-001 The module SHALL have no parameters; the operand width is fixed at 8 bits.
REQ-002 clk  input  1  Single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  Operand pair valid.
REQ-005 in_ready  output  1  Block can accept an operand pair.
REQ-006 a  input  8  Dividend, unsigned.
REQ-007 b  input  8  Divisor, unsigned.
REQ-008 out_valid  output  1  Result valid.
REQ-009 out_ready  input  1  Consumer accepts the result.
REQ-010 u_rdiv8_q  output  8  Quotient.
REQ-011 u_rdiv8_r  output  8  Remainder.
REQ-012 u_rdiv8_dz  output  1  Divide-by-zero flag; this port SHALL exist only when U_RDIV8_DIVZERO_EN is defined.

Function
REQ-013 The block SHALL implement a 3-state FSM with states IDLE, CALC and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 Acceptance SHALL occur when in_valid and in_ready are both 1 on a clock edge; the block SHALL then load Q=a, R=0, B=b and step counter=0, and move to CALC.
REQ-016 In CALC, each cycle SHALL perform one restoring step:
- T = {R, Q[7]} (9 bits); D = T - {0,B}.
- Borrow 0: R<=D[7:0], Q<={Q[6:0],1}.
- Borrow 1: R<=T[7:0], Q<={Q[6:0],0}.
REQ-017 The 9-bit subtraction SHALL be computed as T + ~{0,B} + 1 using a generate/propagate carry-lookahead structure; borrow SHALL equal the inverted carry-out.
REQ-018 After the 8th step the FSM SHALL go to DONE; out_valid SHALL rise exactly 9 cycles after the acceptance edge.
REQ-019 In DONE, u_rdiv8_q and u_rdiv8_r SHALL hold stable until out_valid and out_ready are both 1 on an edge; the FSM SHALL then return to IDLE.
REQ-020 A new operand pair SHALL NOT be accepted in the same cycle a result is consumed; throughput SHALL be one division per 11 cycles minimum.
REQ-021 in_valid SHALL be ignored outside IDLE, and a and b SHALL be ignored except at acceptance.
REQ-022 Results SHALL satisfy a = q*b + r with r < b for all b != 0.
REQ-023 u_rdiv8_q and u_rdiv8_r SHALL reflect internal registers only; there SHALL be no combinational path from any input to any output.

Reset
REQ-024 When rst_n=0, the FSM SHALL go to IDLE immediately, and the following SHALL all be 0: Q, R, B, counter, out_valid, u_rdiv8_q, u_rdiv8_r and u_rdiv8_dz.
REQ-025 in_ready SHALL be 1 on the first edge after rst_n deasserts.
REQ-026 Reset asserted during CALC or DONE SHALL abort the operation, and no result SHALL be presented afterward.

Configuration
REQ-027 Macro U_RDIV8_DIVZERO_EN defined: when b=0 at acceptance, the FSM SHALL go directly to DONE on the next edge with q=0xFF, r=a and u_rdiv8_dz=1. u_rdiv8_dz SHALL be 0 for all b != 0 and SHALL be cleared on the next acceptance.
REQ-028 Macro not defined: the u_rdiv8_dz port SHALL be absent, and b=0 SHALL run the normal 8 steps, yielding q=0xFF and r=a after 9 cycles.

Verification
REQ-029 a=200, b=7 -> after 9 cycles out_valid=1, q=28, r=4.
REQ-030 a=255, b=1 -> q=255, r=0; a=5, b=9 -> q=0, r=5.
REQ-031 a=0x3C, b=0 -> with the macro: out_valid 1 cycle after acceptance, q=0xFF, r=0x3C, dz=1. Without the macro: out_valid after 9 cycles, same q and r.
REQ-032 a=100, b=10, out_ready held 0 for 5 cycles in DONE -> q=10 and r=0 stable, in_ready=0 throughout; IDLE on the first cycle after out_ready=1.
REQ-033 Assert rst_n=0 at CALC step 4 of a=77, b=3 -> out_valid=0, outputs 0, in_ready=1 after release. Then a=77, b=3 -> q=25, r=2.
REQ-034 Exhaustive sweep of all 65536 (a,b) pairs with random out_ready back-pressure -> every result matches the reference model and the REQ-022 identity holds.
